// File: rtl/al_accel_pkg.sv
// Shared types and constants for the max-pool line-buffer feeder.
// AL_ACCEL_LB_VSTRIDE_EN (optional) enables vertical-stride row skipping.
package al_accel_pkg;

  localparam int PIX_W     = 8;
  localparam int VSTRIDE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PRIME  = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } lb_state_e;

endpackage

// File: rtl/al_accel_lb_row_mem.sv
// One row of pixel storage: synchronous write, combinational read at the same address.
module al_accel_lb_row_mem
  import al_accel_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [PIX_W-1:0] wdata_i,
  output logic [PIX_W-1:0] rdata_o
);

  logic [PIX_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/al_accel_pool_line_buf.sv
// Raster pixel stream to 3-row column converter feeding the 3x3 max-pool unit.
// Optional macro AL_ACCEL_LB_VSTRIDE_EN adds cfg_vstride row skipping.
module al_accel_pool_line_buf
  import al_accel_pkg::*;
#(
  parameter int MAX_WIDTH  = 64,
  parameter int MAX_HEIGHT = 64,
  parameter int XW         = $clog2(MAX_WIDTH + 1),
  parameter int YW         = $clog2(MAX_HEIGHT + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [XW-1:0]        cfg_width,
  input  logic [YW-1:0]        cfg_height,
`ifdef AL_ACCEL_LB_VSTRIDE_EN
  input  logic [VSTRIDE_W-1:0] cfg_vstride,
`endif
  output logic                 cfg_err,
  output logic                 busy,
  output logic                 frame_done,
  input  logic                 px_valid,
  output logic                 px_ready,
  input  logic [PIX_W-1:0]     px_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PIX_W-1:0]     out_d0,
  output logic [PIX_W-1:0]     out_d1,
  output logic [PIX_W-1:0]     out_d2,
  output logic                 out_sol,
  output logic                 out_eol,
  output logic                 out_eof,
  output logic [2:0]           dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid & ready are both
  // high; valid never depends on ready, and a held column stays stable until taken.
  localparam int LBAW = $clog2(MAX_WIDTH);

  lb_state_e        state_q, state_d;
  logic [XW-1:0]    x_q, x_d, width_q, width_d;
  logic [YW-1:0]    y_q, y_d, height_q, height_d;
  logic             out_valid_q, out_valid_d;
  logic [PIX_W-1:0] d0_q, d0_d, d1_q, d1_d, d2_q, d2_d;
  logic             sol_q, sol_d, eol_q, eol_d, eof_q, eof_d;
  logic             cfg_err_q, cfg_err_d;
  logic [PIX_W-1:0] lb0_rd, lb1_rd;
  logic             dims_ok, cfg_ok, last_x, last_y, emit_row, last_emit_row;
  logic             accept, load, out_fire;

  assign dims_ok = (cfg_width >= XW'(3)) && (cfg_width <= XW'(MAX_WIDTH)) &&
                   (cfg_height >= YW'(3)) && (cfg_height <= YW'(MAX_HEIGHT));
  assign last_x  = (x_q == width_q - XW'(1));
  assign last_y  = (y_q == height_q - YW'(1));

`ifdef AL_ACCEL_LB_VSTRIDE_EN
  logic [VSTRIDE_W-1:0] vs_q, vs_d, ph_q, ph_d;
  // ph_q counts rows since the last emitting row; a row emits when it wraps to 0.
  assign emit_row      = (ph_q == '0);
  assign last_emit_row = ({1'b0, y_q} + (YW+1)'(vs_q)) >= {1'b0, height_q};
  assign cfg_ok        = dims_ok && (cfg_vstride != '0);
`else
  assign emit_row      = 1'b1;
  assign last_emit_row = last_y;
  assign cfg_ok        = dims_ok;
`endif

  always_comb begin
    px_ready = 1'b0;
    case (state_q)
      ST_PRIME:  px_ready = 1'b1;
      ST_STREAM: px_ready = emit_row ? (~out_valid_q | out_ready) : 1'b1;
      default:   px_ready = 1'b0;
    endcase
  end

  assign accept   = px_valid & px_ready;
  assign load     = accept & (state_q == ST_STREAM) & emit_row;
  assign out_fire = out_valid_q & out_ready;

  al_accel_lb_row_mem #(.DEPTH(MAX_WIDTH)) u_lb0 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (x_q[LBAW-1:0]),
    .wdata_i (px_data),
    .rdata_o (lb0_rd)
  );

  al_accel_lb_row_mem #(.DEPTH(MAX_WIDTH)) u_lb1 (
    .clk_i   (clk),
    .we_i    (accept),
    .addr_i  (x_q[LBAW-1:0]),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    width_d     = width_q;
    height_d    = height_q;
    out_valid_d = out_valid_q;
    d0_d        = d0_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    sol_d       = sol_q;
    eol_d       = eol_q;
    eof_d       = eof_q;
    cfg_err_d   = 1'b0;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
    vs_d        = vs_q;
    ph_d        = ph_q;
`endif

    if (load) begin
      out_valid_d = 1'b1;
      d0_d        = lb1_rd;
      d1_d        = lb0_rd;
      d2_d        = px_data;
      sol_d       = (x_q == '0);
      eol_d       = last_x;
      eof_d       = last_x & last_emit_row;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_ok) begin
            state_d  = ST_PRIME;
            width_d  = cfg_width;
            height_d = cfg_height;
            x_d      = '0;
            y_d      = '0;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
            vs_d     = cfg_vstride;
            ph_d     = '0;
`endif
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_PRIME: begin
        if (accept) begin
          if (last_x) begin
            x_d = '0;
            y_d = y_q + YW'(1);
            if (y_q == YW'(1)) state_d = ST_STREAM;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_STREAM: begin
        if (accept) begin
          if (last_x && last_y) begin
            // A frame ending on a non-emitting row may have nothing left to drain.
            state_d = out_valid_d ? ST_DRAIN : ST_DONE;
          end else if (last_x) begin
            x_d = '0;
            y_d = y_q + YW'(1);
`ifdef AL_ACCEL_LB_VSTRIDE_EN
            ph_d = (ph_q == vs_q - VSTRIDE_W'(1)) ? '0 : ph_q + VSTRIDE_W'(1);
`endif
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (!out_valid_q || out_fire) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      width_q     <= '0;
      height_q    <= '0;
      out_valid_q <= 1'b0;
      d0_q        <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      sol_q       <= 1'b0;
      eol_q       <= 1'b0;
      eof_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
      vs_q        <= '0;
      ph_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      width_q     <= width_d;
      height_q    <= height_d;
      out_valid_q <= out_valid_d;
      d0_q        <= d0_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      sol_q       <= sol_d;
      eol_q       <= eol_d;
      eof_q       <= eof_d;
      cfg_err_q   <= cfg_err_d;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
      vs_q        <= vs_d;
      ph_q        <= ph_d;
`endif
    end
  end

  assign cfg_err    = cfg_err_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign out_valid  = out_valid_q;
  assign out_d0     = d0_q;
  assign out_d1     = d1_q;
  assign out_d2     = d2_q;
  assign out_sol    = sol_q;
  assign out_eol    = eol_q;
  assign out_eof    = eof_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_al_accel_pool_line_buf.sv
// Self-checking bench for al_accel_pool_line_buf: directed and randomized frames
// checked against a frame-level column model (AL_ACCEL_LB_VSTRIDE_EN adds stride cases).
module tb_al_accel_pool_line_buf;
  import al_accel_pkg::*;

  localparam int MAX_WIDTH  = 64;
  localparam int MAX_HEIGHT = 64;
  localparam int XW         = $clog2(MAX_WIDTH + 1);
  localparam int YW         = $clog2(MAX_HEIGHT + 1);
  localparam int COL_W      = 3 * PIX_W + 3;
  localparam int BUDGET     = 20000;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_start;
  logic [XW-1:0] cfg_width;
  logic [YW-1:0] cfg_height;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
  logic [VSTRIDE_W-1:0] cfg_vstride;
`endif
  logic          cfg_err, busy, frame_done;
  logic          px_valid, px_ready;
  logic [7:0]    px_data;
  logic          out_valid, out_ready;
  logic [7:0]    out_d0, out_d1, out_d2;
  logic          out_sol, out_eol, out_eof;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [COL_W-1:0] exp_q[$];
  logic [7:0]       fpx [0:4095];

  always #5 clk = ~clk;

  al_accel_pool_line_buf #(.MAX_WIDTH(MAX_WIDTH), .MAX_HEIGHT(MAX_HEIGHT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_start  (cfg_start),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
`ifdef AL_ACCEL_LB_VSTRIDE_EN
    .cfg_vstride(cfg_vstride),
`endif
    .cfg_err    (cfg_err),
    .busy       (busy),
    .frame_done (frame_done),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_data    (px_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_d0     (out_d0),
    .out_d1     (out_d1),
    .out_d2     (out_d2),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .out_eof    (out_eof),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      $error("check %s", tag);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected columns from the frame image: rows y>=2 whose (y-2) is a multiple of s.
  task automatic build_model(input int w, input int h, input int s);
    logic [COL_W-1:0] c;
    exp_q.delete();
    for (int y = 2; y < h; y++) begin
      if ((y - 2) % s == 0) begin
        for (int x = 0; x < w; x++) begin
          c = {fpx[(y-2)*w + x], fpx[(y-1)*w + x], fpx[y*w + x], 1'(x == 0), 1'(x == w-1), 1'b0};
          exp_q.push_back(c);
        end
      end
    end
    c = exp_q.pop_back();
    c[0] = 1'b1;
    exp_q.push_back(c);
  endtask

  task automatic start_cfg(input int w, input int h, input int s);
    cfg_width  = XW'(w);
    cfg_height = YW'(h);
`ifdef AL_ACCEL_LB_VSTRIDE_EN
    cfg_vstride = VSTRIDE_W'(s);
`else
    if (s != 1) $display("note: stride %0d needs the stride build", s);
`endif
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  // mode 0: always ready; mode 1: 3-cycle stall at cycle stall_at; mode 2: random traffic.
  task automatic run_frame(input int w, input int h, input int s, input int mode, input int stall_at);
    int sent = 0, cyc = 0, last_hs = -100, fd_cnt = 0;
    int total = w * h;
    bit holding = 0;
    logic [COL_W-1:0] got, held, e;
    build_model(w, h, s);
    start_cfg(w, h, s);
    check("busy_after_start", busy, 1);
    while (fd_cnt == 0 && cyc < BUDGET) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(cyc >= stall_at && cyc < stall_at + 3);
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      px_valid  = (sent < total) && (mode != 2 || $urandom_range(0, 4) != 0);
      px_data   = fpx[sent < total ? sent : 0];
      cfg_start = (mode == 2 && cyc == 20);
      if (cfg_start) begin
        cfg_width  = XW'(2);
        cfg_height = YW'(3);
      end
      #1;
      got = {out_d0, out_d1, out_d2, out_sol, out_eol, out_eof};
      if (holding) begin
        check("hold_column", got, held);
        check("hold_valid", out_valid, 1);
      end
      if (out_valid && !out_ready && s == 1) check("bp_px_ready", px_ready, 0);
      if (mode == 2 && cyc == 21) check("start_while_busy_no_err", cfg_err, 0);
      holding = out_valid && !out_ready;
      held    = got;
      if (frame_done) begin
        fd_cnt++;
        check("fd_all_columns", exp_q.size(), 0);
        check("fd_all_pixels", sent, total);
        if (s == 1) check("fd_latency", cyc - last_hs, 1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_column", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("column", got, e);
        end
        last_hs = cyc;
      end
      if (px_valid && px_ready) sent++;
      cyc++;
      tick();
    end
    if (cyc >= BUDGET) check("frame_timeout", 0, 1);
    px_valid  = 1'b0;
    cfg_start = 1'b0;
    out_ready = 1'b1;
    #1;
    check("fd_one_cycle", frame_done, 0);
    check("idle_after_frame", busy, 0);
    tick();
  endtask

  initial begin
    int w, h;
    rst = 1'b1; cfg_start = 1'b0; cfg_width = '0; cfg_height = '0;
`ifdef AL_ACCEL_LB_VSTRIDE_EN
    cfg_vstride = VSTRIDE_W'(1);
`endif
    px_valid = 1'b0; px_data = '0; out_ready = 1'b1;
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_px_ready", px_ready, 0);
    check("reset_state", dbg_state, 3'(ST_IDLE));
    tick(); tick();
    rst = 1'b0;
    tick();

    // nominal 4x3 frame, pixels 0..11
    for (int i = 0; i < 12; i++) fpx[i] = 8'(i);
    run_frame(4, 3, 1, 0, 0);

    // signed pass-through
    for (int i = 0; i < 3; i++) begin
      fpx[i] = 8'h80; fpx[3 + i] = 8'h7f; fpx[6 + i] = 8'hff;
    end
    run_frame(3, 3, 1, 0, 0);

    // 3-cycle output stall mid-row
    for (int i = 0; i < 20; i++) fpx[i] = 8'($urandom_range(0, 255));
    run_frame(5, 4, 1, 1, 12);

    // rejected configurations
    for (int k = 0; k < 3; k++) begin
      w = (k == 0) ? 2 : (k == 1) ? MAX_WIDTH + 1 : 4;
      h = (k == 2) ? 2 : 5;
      start_cfg(w, h, 1);
      #1;
      check("cfg_err_pulse", cfg_err, 1);
      check("cfg_err_stays_idle", dbg_state, 3'(ST_IDLE));
      tick();
      #1;
      check("cfg_err_clears", cfg_err, 0);
      tick();
    end

    // async reset right after the 7th accepted pixel (first streaming pixel)
    for (int i = 0; i < 12; i++) fpx[i] = 8'(100 + i);
    start_cfg(3, 4, 1);
    out_ready = 1'b0;
    begin
      int acc = 0, guard = 0;
      while (acc < 7 && guard < 100) begin
        px_valid = 1'b1;
        px_data  = fpx[acc];
        #1;
        if (px_ready) acc++;
        guard++;
        tick();
      end
      check("pre_reset_accepts", acc, 7);
    end
    px_valid = 1'b0;
    #1;
    check("pre_reset_out_valid", out_valid, 1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_outputs", {out_d0, out_d1, out_d2, out_sol, out_eol, out_eof}, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_px_ready", px_ready, 0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 12; i++) fpx[i] = 8'($urandom_range(0, 255));
    run_frame(4, 3, 1, 0, 0);

    // widest row
    for (int i = 0; i < MAX_WIDTH * 3; i++) fpx[i] = 8'($urandom_range(0, 255));
    run_frame(MAX_WIDTH, 3, 1, 0, 0);

    // randomized frames with random traffic and an ignored mid-frame start
    for (int f = 0; f < 4; f++) begin
      w = $urandom_range(3, 9);
      h = $urandom_range(3, 7);
      for (int i = 0; i < w * h; i++) fpx[i] = 8'($urandom_range(0, 255));
      run_frame(w, h, 1, 2, 0);
    end

`ifdef AL_ACCEL_LB_VSTRIDE_EN
    start_cfg(4, 4, 0);
    #1;
    check("vstride0_cfg_err", cfg_err, 1);
    tick();
    for (int i = 0; i < 18; i++) fpx[i] = 8'(i);
    run_frame(3, 6, 2, 0, 0);
    for (int f = 0; f < 3; f++) begin
      w = $urandom_range(3, 8);
      h = $urandom_range(3, 9);
      for (int i = 0; i < w * h; i++) fpx[i] = 8'($urandom_range(0, 255));
      run_frame(w, h, $urandom_range(2, 3), 2, 0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/al_accel_pool_line_buf.md
Name: al_accel_pool_line_buf

Overview:
- Upstream feeder for the 3x3 max-pool column unit; converts a raster int8 pixel stream (one pixel/beat) into vertically aligned 3-pixel columns (rows y-2, y-1, y).
- Holds two previous rows in line buffers; emits one column per accepted pixel once two rows are primed.
- Provides row/frame markers for the pool controller, which drives the pool unit's clear/enable from them.

Parameters:
- MAX_WIDTH, 64, maximum row length in pixels (line buffer depth).
- MAX_HEIGHT, 64, maximum frame height in rows.
- XW, $clog2(MAX_WIDTH+1), column counter / cfg_width width.
- YW, $clog2(MAX_HEIGHT+1), row counter / cfg_height width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cfg_start  in  1  one-cycle pulse; latches cfg_width/cfg_height and starts a frame.
- cfg_width  in  XW  row length in pixels.
- cfg_height  in  YW  frame height in rows.
- cfg_err  out  1  one-cycle pulse on rejected cfg_start.
- busy  out  1  high from accepted start until frame_done.
- frame_done  out  1  one-cycle pulse at frame end.
- px_valid  in  1  input pixel valid.
- px_ready  out  1  input pixel accepted when px_valid & px_ready.
- px_data  in  8  signed pixel.
- out_valid  out  1  column valid.
- out_ready  in  1  downstream accepts column.
- out_d0  out  8  signed pixel, row y-2 (oldest); maps to pool input 0.
- out_d1  out  8  signed pixel, row y-1.
- out_d2  out  8  signed pixel, row y (current).
- out_sol  out  1  column is x==0.
- out_eol  out  1  column is x==width-1.
- out_eof  out  1  last column of the frame.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; counters 0. Line-buffer contents are not reset and are don't-care.
- FSM states: IDLE, PRIME, STREAM, DRAIN, DONE.
  - IDLE -> PRIME on cfg_start with 3<=cfg_width<=MAX_WIDTH and 3<=cfg_height<=MAX_HEIGHT.
  - On an invalid cfg_start: cfg_err pulses the next cycle and the state stays IDLE.
  - cfg_start while not IDLE is ignored, with no cfg_err.
  - PRIME: rows 0 and 1; px_ready=1; no output. PRIME -> STREAM after the last pixel of row 1 is accepted.
  - STREAM: px_ready = ~out_valid | out_ready (single output register, full throughput). Each accept loads out_d0=lb1[x], out_d1=lb0[x], out_d2=px_data plus the markers, and sets out_valid.
  - STREAM -> DRAIN on accept of the last pixel (x=width-1, y=height-1).
  - DRAIN: px_ready=0; waits for the out handshake, then goes to DONE.
  - DONE: frame_done=1 for one cycle, then IDLE.
- Line buffers update on every accepted pixel in PRIME/STREAM: lb1[x]<=lb0[x]; lb0[x]<=px_data. Reads are combinational at the current x.
- Counters: x wraps to 0 at width-1 and y increments; y never exceeds height-1.
- Latency: column appears one cycle after the pixel is accepted.
- Backpressure: while out_valid & ~out_ready, all out_* are held stable and px_ready=0.
- out_valid deasserts after a handshake with no new accept in the same cycle.
- Data: pixels pass through unmodified as signed 8-bit; no arithmetic.
- busy=1 in PRIME/STREAM/DRAIN/DONE.

Optional Feature:
- Macro: AL_ACCEL_LB_VSTRIDE_EN.
- With the macro defined:
  - Adds port cfg_vstride (in, 2 bits, latched at start; 0 is rejected with cfg_err).
  - Columns are emitted only on rows where (y-2) mod cfg_vstride == 0.
  - Non-emitting rows in STREAM still update the line buffers, with px_ready=1.
  - out_eof marks the last emitted column; if the final row is non-emitting, DRAIN is skipped and frame_done still pulses.
- Without the macro: every row y>=2 emits; there is no cfg_vstride port.

Decomposition:
- Package al_accel_pkg holds:
  - the state enum;
  - the pixel width constant (8);
  - the cfg_vstride width constant.
- Sub-module al_accel_lb_row_mem: one MAX_WIDTH x 8 row memory with sync write and async read. Instantiated twice (lb0, lb1).

Test Plan:
- Nominal frame: width=4, height=3, pixels 0..11 with out_ready=1 -> columns (0,4,8),(1,5,9),(2,6,10),(3,7,11). out_sol on the first column; out_eol and out_eof on the last; frame_done one cycle after the last handshake.
- Signed pass-through: rows of -128,127,-1 -> out_d0=-128, out_d1=127, out_d2=-1 bit-exact.
- Backpressure: out_ready=0 for 3 cycles mid-row -> out_* frozen and px_ready=0; no pixel lost or duplicated.
- Config errors: cfg_width=2 -> cfg_err pulses and state stays IDLE. cfg_start while busy is ignored.
- Async reset at the 7th pixel -> all outputs 0 immediately. A following valid frame produces correct columns.
- VSTRIDE_EN, stride=2, height=6, width=3 -> only rows y=2 and y=4 emit (6 columns); out_eof on the last column of y=4; frame_done still pulses.
